regfile_dbg_ctrl: RTL and testbench

Byte-stream debug controller that drives the 4×16-bit register file from outside the core. It accepts command bytes over a valid/ready channel and performs register reads or writes through the register file's write port and one read port. It returns response bytes over a second valid/ready channel. It sits between the host debug link (UART byte layer) and the register file, and owns the write port whenever the core is halted.

---
 rtl/regfile_dbg_pkg.sv | 38 +++
 rtl/regfile_dbg_timer.sv | 31 +++
 rtl/regfile_dbg_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_regfile_dbg_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dbg_pkg.sv
// Shared types and constants for the register-file debug controller.
// The READ_ALL opcode is built only when REGFILE_DBG_READ_ALL_EN is defined.
package regfile_dbg_pkg;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_READ     = 2'b01,
    OP_WRITE    = 2'b10,
    OP_READ_ALL = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_HI,
    ST_WR_LO,
    ST_WR_COMMIT,
    ST_SNAP,
    ST_RSP_HI,
    ST_RSP_LO,
    ST_RSP_BYTE
  } state_e;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int RSV_MSB = 5;
  localparam int RSV_LSB = 2;
  localparam int REG_MSB = 1;
  localparam int REG_LSB = 0;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hA5;
  localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

  // An opcode is only well-formed when its reserved middle field is all zero.
  function automatic logic rsvFieldClear(input logic [7:0] opByte);
    return (opByte[RSV_MSB:RSV_LSB] == 4'b0000);
  endfunction

endpackage

// File: rtl/regfile_dbg_timer.sv
// Inter-byte idle counter for WRITE payloads; o_expired marks the
// TIMEOUT_CYCLES-th consecutive enabled cycle without a clear.
module regfile_dbg_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_i,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Saturates on the terminal value so a stalled FSM never wraps the count.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/regfile_dbg_ctrl.sv
// Byte-stream debug controller owning the register-file write port.
// Optional feature macro: REGFILE_DBG_READ_ALL_EN enables the READ_ALL opcode.
module regfile_dbg_ctrl
  import regfile_dbg_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] ACK_BYTE       = DEFAULT_ACK_BYTE,
  parameter logic [7:0] ERR_BYTE       = DEFAULT_ERR_BYTE
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [7:0]  cmd_data_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic [7:0]  rsp_data_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rf_in_o,
  output logic [1:0]  rf_in_sel_o,
  output logic        rf_in_en_o,
  output logic [1:0]  rf_out_sel_o,
  input  logic [15:0] rf_out_i
);

  state_e      r_state;
  logic        r_cmdReady;
  logic        r_rspValid;
  logic [7:0]  r_rspByte;
  logic [15:0] r_shadow;
  logic [15:0] r_rfIn;
  logic [1:0]  r_rfInSel;
  logic        r_rfInEn;
  logic [1:0]  r_rfOutSel;
  logic [1:0]  r_wrReg;
  logic [7:0]  r_wrHi;
`ifdef REGFILE_DBG_READ_ALL_EN
  logic [1:0]  r_index;
  logic        r_readAll;
`endif

  logic       w_cmdFire;
  logic       w_inWrite;
  logic       w_expired;
  logic       w_rsvClear;
  op_e        w_op;
  logic [1:0] w_reg;
  logic [7:0] w_rspData;

  assign w_cmdFire  = cmd_valid_i && r_cmdReady;
  assign w_inWrite  = (r_state == ST_WR_HI) || (r_state == ST_WR_LO);
  assign w_rsvClear = rsvFieldClear(cmd_data_i);
  assign w_op       = op_e'(cmd_data_i[OP_MSB:OP_LSB]);
  assign w_reg      = cmd_data_i[REG_MSB:REG_LSB];

  regfile_dbg_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset_i  (reset_i),
    .i_clear  (w_cmdFire || !w_inWrite),
    .i_enable (w_inWrite),
    .o_expired(w_expired)
  );

  // Control FSM; every output is registered here alongside the state.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_cmdReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspByte  <= '0;
      r_shadow   <= '0;
      r_rfIn     <= '0;
      r_rfInSel  <= '0;
      r_rfInEn   <= 1'b0;
      r_rfOutSel <= '0;
      r_wrReg    <= '0;
      r_wrHi     <= '0;
`ifdef REGFILE_DBG_READ_ALL_EN
      r_index    <= '0;
      r_readAll  <= 1'b0;
`endif
    end else begin
      r_rfInEn <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmdFire) begin
            r_cmdReady <= 1'b0;
            if (!w_rsvClear) begin
              r_rspByte  <= ERR_BYTE;
              r_rspValid <= 1'b1;
              r_state    <= ST_RSP_BYTE;
            end else begin
              case (w_op)
                OP_NOP: begin
                  r_rspByte  <= ACK_BYTE;
                  r_rspValid <= 1'b1;
                  r_state    <= ST_RSP_BYTE;
                end
                OP_READ: begin
                  r_rfOutSel <= w_reg;
`ifdef REGFILE_DBG_READ_ALL_EN
                  r_readAll  <= 1'b0;
`endif
                  r_state    <= ST_SNAP;
                end
                OP_WRITE: begin
                  r_wrReg    <= w_reg;
                  r_cmdReady <= 1'b1;
                  r_state    <= ST_WR_HI;
                end
                default: begin
`ifdef REGFILE_DBG_READ_ALL_EN
                  r_rfOutSel <= 2'd0;
                  r_index    <= 2'd0;
                  r_readAll  <= 1'b1;
                  r_state    <= ST_SNAP;
`else
                  r_rspByte  <= ERR_BYTE;
                  r_rspValid <= 1'b1;
                  r_state    <= ST_RSP_BYTE;
`endif
                end
              endcase
            end
          end
        end
        ST_WR_HI: begin
          if (w_cmdFire) begin
            r_wrHi  <= cmd_data_i;
            r_state <= ST_WR_LO;
          end else if (w_expired) begin
            r_cmdReady <= 1'b0;
            r_rspByte  <= ERR_BYTE;
            r_rspValid <= 1'b1;
            r_state    <= ST_RSP_BYTE;
          end
        end
        ST_WR_LO: begin
          if (w_cmdFire) begin
            r_rfIn     <= {r_wrHi, cmd_data_i};
            r_rfInSel  <= r_wrReg;
            r_rfInEn   <= 1'b1;
            r_cmdReady <= 1'b0;
            r_state    <= ST_WR_COMMIT;
          end else if (w_expired) begin
            r_cmdReady <= 1'b0;
            r_rspByte  <= ERR_BYTE;
            r_rspValid <= 1'b1;
            r_state    <= ST_RSP_BYTE;
          end
        end
        ST_WR_COMMIT: begin
          r_rspByte  <= ACK_BYTE;
          r_rspValid <= 1'b1;
          r_state    <= ST_RSP_BYTE;
        end
        ST_SNAP: begin
          r_shadow   <= rf_out_i;
          r_rspValid <= 1'b1;
          r_state    <= ST_RSP_HI;
        end
        ST_RSP_HI: begin
          if (rsp_ready_i) begin
            r_state <= ST_RSP_LO;
          end
        end
        ST_RSP_LO: begin
          if (rsp_ready_i) begin
            r_rspValid <= 1'b0;
`ifdef REGFILE_DBG_READ_ALL_EN
            if (r_readAll && (r_index != 2'd3)) begin
              r_index    <= r_index + 2'd1;
              r_rfOutSel <= r_index + 2'd1;
              r_state    <= ST_SNAP;
            end else begin
              r_cmdReady <= 1'b1;
              r_state    <= ST_IDLE;
            end
`else
            r_cmdReady <= 1'b1;
            r_state    <= ST_IDLE;
`endif
          end
        end
        ST_RSP_BYTE: begin
          if (rsp_ready_i) begin
            r_rspValid <= 1'b0;
            r_cmdReady <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Response byte is picked from registered state only, so it is stable under backpressure.
  always_comb begin
    w_rspData = '0;
    case (r_state)
      ST_RSP_HI:   w_rspData = r_shadow[15:8];
      ST_RSP_LO:   w_rspData = r_shadow[7:0];
      ST_RSP_BYTE: w_rspData = r_rspByte;
      default:     w_rspData = '0;
    endcase
  end

  assign cmd_ready_o  = r_cmdReady;
  assign rsp_valid_o  = r_rspValid;
  assign rsp_data_o   = w_rspData;
  assign rf_in_o      = r_rfIn;
  assign rf_in_sel_o  = r_rfInSel;
  assign rf_in_en_o   = r_rfInEn;
  assign rf_out_sel_o = r_rfOutSel;

endmodule

// File: tb/tb_regfile_dbg_ctrl.sv
// Self-checking bench for regfile_dbg_ctrl: vector table, corner sequences and random commands
// against a byte-level model of the debug protocol (REGFILE_DBG_READ_ALL_EN aware).
module tb_regfile_dbg_ctrl;

  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  cmd_data_i = '0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  rsp_data_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [15:0] rf_in_o;
  logic [1:0]  rf_in_sel_o;
  logic        rf_in_en_o;
  logic [1:0]  rf_out_sel_o;
  logic [15:0] rf_out_i;

  int checks = 0;
  int failures = 0;

  regfile_dbg_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .ACK_BYTE(8'hA5),
    .ERR_BYTE(8'hEE)
  ) dut (
    .clk(clk), .reset_i(reset_i),
    .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rf_in_o(rf_in_o), .rf_in_sel_o(rf_in_sel_o), .rf_in_en_o(rf_in_en_o),
    .rf_out_sel_o(rf_out_sel_o), .rf_out_i(rf_out_i)
  );

  always #5 clk = ~clk;

  // Register file stand-in; the poke port plays the role of the core changing a register.
  logic [15:0] tbRegs [4];
  logic        pokeEn = 1'b0;
  logic [1:0]  pokeSel = '0;
  logic [15:0] pokeData = '0;
  int          enCount = 0;
  int          pulseErr = 0;
  logic        prevEn = 1'b0;
  logic [15:0] lastWrData = '0;
  logic [1:0]  lastWrSel = '0;

  always @(posedge clk) begin
    if (pokeEn) tbRegs[pokeSel] <= pokeData;
    else if (rf_in_en_o) tbRegs[rf_in_sel_o] <= rf_in_o;
    if (rf_in_en_o) begin
      enCount    <= enCount + 1;
      lastWrData <= rf_in_o;
      lastWrSel  <= rf_in_sel_o;
    end
    if (rf_in_en_o && prevEn) pulseErr <= pulseErr + 1;
    prevEn <= rf_in_en_o;
  end

  assign rf_out_i = tbRegs[rf_out_sel_o];

  // Protocol-level model: command in, list of response bytes out.
  logic [15:0] modelRegs [4];
  logic [7:0]  expQ [$];
  int          expWrites = 0;
  logic [7:0]  gotBytes [8];

  function automatic void modelCmd(input logic [7:0] op, input logic [15:0] data);
    int r;
    r = int'(op[1:0]);
    if (op[5:2] != 4'b0000) begin
      expQ.push_back(8'hEE);
      return;
    end
    case (op[7:6])
      2'b00: expQ.push_back(8'hA5);
      2'b01: begin
        expQ.push_back(modelRegs[r][15:8]);
        expQ.push_back(modelRegs[r][7:0]);
      end
      2'b10: begin
        modelRegs[r] = data;
        expWrites++;
        expQ.push_back(8'hA5);
      end
      default: begin
`ifdef REGFILE_DBG_READ_ALL_EN
        for (int k = 0; k < 4; k++) begin
          expQ.push_back(modelRegs[k][15:8]);
          expQ.push_back(modelRegs[k][7:0]);
        end
`else
        expQ.push_back(8'hEE);
`endif
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    cmd_data_i  = b;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) begin
      checkOutput("cmd_ready_wait", 32'(cmd_ready_o), 32'd1);
      cmd_valid_i = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic recvByte(output logic [7:0] b, input int stall);
    int n = 0;
    rsp_ready_i = 1'b0;
    repeat (stall) @(negedge clk);
    rsp_ready_i = 1'b1;
    while (!rsp_valid_o && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid_o) begin
      checkOutput("rsp_valid_wait", 32'(rsp_valid_o), 32'd1);
      b = 8'h00;
      rsp_ready_i = 1'b0;
      return;
    end
    b = rsp_data_o;
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  task automatic runCmd(input logic [7:0] op, input logic [15:0] data, input int nRsp, input int stall);
    logic [7:0] b;
    sendByte(op);
    if (op[5:2] == 4'b0000 && op[7:6] == 2'b10) begin
      sendByte(data[15:8]);
      sendByte(data[7:0]);
    end
    for (int i = 0; i < nRsp; i++) begin
      recvByte(b, stall);
      gotBytes[i] = b;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [15:0] data, input int stall);
    int n;
    expQ.delete();
    modelCmd(op, data);
    n = expQ.size();
    runCmd(op, data, n, stall);
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("op%02h_rsp%0d", op, i), 32'(gotBytes[i]), 32'(expQ[i]));
  endtask

  task automatic pokeReg(input logic [1:0] sel, input logic [15:0] val);
    pokeEn   = 1'b1;
    pokeSel  = sel;
    pokeData = val;
    @(negedge clk);
    pokeEn = 1'b0;
    modelRegs[sel] = val;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] data;
    int          nRsp;
    logic [7:0]  rsp0;
    logic [7:0]  rsp1;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    int enBefore;
    logic [1:0]  opc;
    logic [3:0]  rsv;
    logic [1:0]  rg;
    logic [15:0] rdata;

    vecs[0] = '{8'h00, 16'h0000, 1, 8'hA5, 8'h00};
    vecs[1] = '{8'h82, 16'h1234, 1, 8'hA5, 8'h00};
    vecs[2] = '{8'h42, 16'h0000, 2, 8'h12, 8'h34};
    vecs[3] = '{8'h44, 16'h0000, 1, 8'hEE, 8'h00};
    vecs[4] = '{8'h81, 16'hABCD, 1, 8'hA5, 8'h00};
    vecs[5] = '{8'h41, 16'h0000, 2, 8'hAB, 8'hCD};
    vecs[6] = '{8'h3F, 16'h0000, 1, 8'hEE, 8'h00};
    vecs[7] = '{8'h83, 16'h0F0F, 1, 8'hA5, 8'h00};
    vecs[8] = '{8'h43, 16'h0000, 2, 8'h0F, 8'h0F};
    vecs[9] = '{8'h40, 16'h0000, 2, 8'h00, 8'h00};

    repeat (2) @(negedge clk);
    checkOutput("reset_cmd_ready", 32'(cmd_ready_o), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("reset_rsp_data", 32'(rsp_data_o), 32'd0);
    checkOutput("reset_rf_in_en", 32'(rf_in_en_o), 32'd0);
    checkOutput("reset_rf_in", 32'(rf_in_o), 32'd0);
    checkOutput("reset_rf_in_sel", 32'(rf_in_sel_o), 32'd0);
    checkOutput("reset_rf_out_sel", 32'(rf_out_sel_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) pokeReg(2'(i), 16'h0000);

    for (int i = 0; i < 10; i++) begin
      expQ.delete();
      modelCmd(vecs[i].op, vecs[i].data);
      runCmd(vecs[i].op, vecs[i].data, vecs[i].nRsp, i % 3);
      checkOutput($sformatf("vec%0d_rsp0", i), 32'(gotBytes[0]), 32'(vecs[i].rsp0));
      if (vecs[i].nRsp == 2)
        checkOutput($sformatf("vec%0d_rsp1", i), 32'(gotBytes[1]), 32'(vecs[i].rsp1));
      if (vecs[i].op[7:6] == 2'b10 && vecs[i].op[5:2] == 4'b0000) begin
        checkOutput($sformatf("vec%0d_wr_data", i), 32'(lastWrData), 32'(vecs[i].data));
        checkOutput($sformatf("vec%0d_wr_sel", i), 32'(lastWrSel), 32'(vecs[i].op[1:0]));
      end
      if (i == 0) begin
        checkOutput("nop_rf_in", 32'(rf_in_o), 32'd0);
        checkOutput("nop_rf_in_sel", 32'(rf_in_sel_o), 32'd0);
        checkOutput("nop_rf_out_sel", 32'(rf_out_sel_o), 32'd0);
        checkOutput("nop_rf_en_count", 32'(enCount), 32'd0);
      end
    end
    checkOutput("table_write_count", 32'(enCount), 32'(expWrites));

    // Backpressure: hold the hi byte for 20 cycles.
    sendByte(8'h41);
    waited = 0;
    while (!rsp_valid_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < 20; i++) begin
      checkOutput("stall_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("stall_data", 32'(rsp_data_o), 32'(modelRegs[1][15:8]));
      @(negedge clk);
    end
    recvByte(gotBytes[0], 0);
    recvByte(gotBytes[1], 0);
    checkOutput("stall_hi", 32'(gotBytes[0]), 32'hAB);
    checkOutput("stall_lo", 32'(gotBytes[1]), 32'hCD);

    // Shadow: core rewrites x2 while the hi byte is pending.
    sendByte(8'h42);
    waited = 0;
    while (!rsp_valid_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    pokeReg(2'd2, 16'hFFFF);
    recvByte(gotBytes[0], 1);
    recvByte(gotBytes[1], 0);
    checkOutput("shadow_hi", 32'(gotBytes[0]), 32'h12);
    checkOutput("shadow_lo", 32'(gotBytes[1]), 32'h34);
    applyStimulus(8'h42, 16'h0000, 0);

    // Timeout in WR_LO.
    enBefore = enCount;
    sendByte(8'h81);
    sendByte(8'hAB);
    rsp_ready_i = 1'b1;
    waited = 0;
    while (!rsp_valid_o && waited < TIMEOUT + 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("timeout_rsp", 32'(rsp_data_o), 32'hEE);
    checkOutput("timeout_window", 32'(waited >= TIMEOUT - 1 && waited <= TIMEOUT + 2), 32'd1);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    checkOutput("timeout_no_write", 32'(enCount), 32'(enBefore));
    applyStimulus(8'h00, 16'h0000, 0);
    applyStimulus(8'h41, 16'h0000, 0);

    // Reset between hi and lo payload bytes.
    enBefore = enCount;
    sendByte(8'h82);
    sendByte(8'h55);
    reset_i = 1'b1;
    #1;
    checkOutput("mid_reset_cmd_ready", 32'(cmd_ready_o), 32'd1);
    checkOutput("mid_reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("mid_reset_rf_in_en", 32'(rf_in_en_o), 32'd0);
    checkOutput("mid_reset_rf_in", 32'(rf_in_o), 32'd0);
    checkOutput("mid_reset_rf_in_sel", 32'(rf_in_sel_o), 32'd0);
    checkOutput("mid_reset_rf_out_sel", 32'(rf_out_sel_o), 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset_no_write", 32'(enCount), 32'(enBefore));
    applyStimulus(8'h42, 16'h0000, 0);

    // READ_ALL over preloaded 1,2,3,4.
    for (int i = 0; i < 4; i++) pokeReg(2'(i), 16'(i + 1));
`ifdef REGFILE_DBG_READ_ALL_EN
    runCmd(8'hC0, 16'h0000, 8, 1);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("read_all_%0d", i), 32'(gotBytes[i]), (i % 2 == 1) ? 32'(i / 2 + 1) : 32'd0);
`else
    runCmd(8'hC0, 16'h0000, 1, 0);
    checkOutput("read_all_disabled", 32'(gotBytes[0]), 32'hEE);
`endif

    // Randomized command stream against the model.
    for (int i = 0; i < 40; i++) begin
      opc   = 2'($urandom_range(0, 3));
      rg    = 2'($urandom_range(0, 3));
      rsv   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      rdata = 16'($urandom);
      applyStimulus({opc, rsv, rg}, rdata, int'($urandom_range(0, 2)));
    end
    checkOutput("final_write_count", 32'(enCount), 32'(expWrites));
    checkOutput("single_cycle_strobe", 32'(pulseErr), 32'd0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("final_reg%0d", i), 32'(tbRegs[i]), 32'(modelRegs[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
